crc_stream: RTL

- Streaming multi-hash CRC engine for the bloom-filter datapath.
- Accepts a string of arbitrary length as beats of BYTES_PER_CYCLE bytes over a valid/ready stream.
- Runs N_HASH independent CRC channels in parallel. All channels share one polynomial; each has its own init value.
- After the final beat it presents all hashes and the string length on a registered, back-pressurable result port that feeds bit-index generation.

---
 rtl/crc_stream.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/crc_stream.sv
// ---------------------------------------------------------------------------
// crc_stream
//   Streaming multi-hash CRC engine for the bloom-filter datapath. A string of
//   any length arrives as beats of BYTES_PER_CYCLE bytes. N_HASH CRC channels
//   share one polynomial and differ only in their init value. After the final
//   beat, every hash and the byte length are presented on a registered,
//   back-pressurable result port.
//
// Ports
//   clk_i        clock
//   rst_n_i      asynchronous active-low reset
//   data_i       byte lanes, lane 0 holds the earliest byte
//   valid_i      beat valid
//   eop_i        last beat of the string
//   empty_i      unused high lanes on the eop beat
//   ready_o      beat accepted when valid_i && ready_o
//   res_o        CRC results, channel i at [i*WIDTH +: WIDTH]
//   len_o        string length in bytes (saturating)
//   res_valid_o  result valid
//   res_ready_i  result consumed when res_valid_o && res_ready_i
//   err_o        sticky protocol error (bad empty_i or length saturation)
// ---------------------------------------------------------------------------
module crc_stream #(
  parameter int                             BYTE_W          = 8,
  parameter int                             WIDTH           = 16,
  parameter logic [63:0]                    POLY            = 64'h8D95,
  parameter int                             N_HASH          = 4,
  parameter logic [N_HASH-1:0][WIDTH-1:0]   INIT_VEC        = {16'h0001, 16'h00FF, 16'h0F0F, 16'hFFFF},
  parameter int                             BYTES_PER_CYCLE = 4,
  parameter int                             LEN_W           = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [BYTES_PER_CYCLE*BYTE_W-1:0] data_i,
  input  logic                              valid_i,
  input  logic                              eop_i,
  input  logic [$clog2(BYTES_PER_CYCLE):0]  empty_i,
  output logic                              ready_o,
  output logic [N_HASH*WIDTH-1:0]           res_o,
  output logic [LEN_W-1:0]                  len_o,
  output logic                              res_valid_o,
  input  logic                              res_ready_i,
  output logic                              err_o
);

  localparam int                 LANES_W = BYTES_PER_CYCLE * BYTE_W;
  localparam int                 EMPTY_W = $clog2(BYTES_PER_CYCLE) + 1;
  localparam int                 SUM_W   = LEN_W + 1;
  localparam logic [EMPTY_W-1:0] BPC_E   = EMPTY_W'(BYTES_PER_CYCLE);
  localparam logic [WIDTH-1:0]   POLY_W  = POLY[WIDTH-1:0];

  // Parameter sanity checks, resolved at elaboration.
  if (WIDTH < BYTE_W) begin : g_chk_width
    $error("crc_stream: WIDTH must be >= BYTE_W");
  end
  if (WIDTH < 64) begin : g_chk_poly
    if (POLY >= (64'd1 << WIDTH)) begin : g_bad_poly
      $error("crc_stream: POLY must be < 2**WIDTH");
    end
  end
  if (BYTES_PER_CYCLE < 1) begin : g_chk_bpc
    $error("crc_stream: BYTES_PER_CYCLE must be >= 1");
  end

  // MSB-first, non-reflected CRC over one byte.
  function automatic logic [WIDTH-1:0] crc_byte(input logic [WIDTH-1:0]  crc,
                                                input logic [BYTE_W-1:0] d);
    logic [WIDTH-1:0] c;
    logic             fb;
    c = crc;
    for (int b = BYTE_W - 1; b >= 0; b--) begin
      fb = c[WIDTH-1] ^ d[b];
      c  = c << 1;
      if (fb) c = c ^ POLY_W;
    end
    return c;
  endfunction

  // Apply the first nvld lanes, lane 0 first.
  function automatic logic [WIDTH-1:0] crc_beat(input logic [WIDTH-1:0]   crc,
                                                input logic [LANES_W-1:0] d,
                                                input logic [EMPTY_W-1:0] nvld);
    logic [WIDTH-1:0] c;
    c = crc;
    for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
      if (l < int'(nvld)) c = crc_byte(c, d[l*BYTE_W +: BYTE_W]);
    end
    return c;
  endfunction

  // Saturating length add; MSB of the result flags that saturation occurred.
  function automatic logic [SUM_W-1:0] sat_add(input logic [LEN_W-1:0]   len,
                                               input logic [EMPTY_W-1:0] inc);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, len} + SUM_W'(inc);
    if (sum[LEN_W]) return {1'b1, {LEN_W{1'b1}}};
    return sum;
  endfunction

  logic [N_HASH-1:0][WIDTH-1:0] crc_p0;
  logic [N_HASH-1:0][WIDTH-1:0] crc_nxt;
  logic [LEN_W-1:0]             len_p0;
  logic [SUM_W-1:0]             len_sum;
  logic [EMPTY_W-1:0]           nvld;
  logic                         empty_bad;
  logic                         accept;

  // Result held and not being drained: stall every beat, eop or not, so that
  // ready_o never depends on eop_i.
  assign ready_o = !res_valid_o || res_ready_i;
  assign accept  = valid_i && ready_o;

  // An out-of-range empty_i turns the final beat into a zero-byte beat.
  always_comb begin
    empty_bad = eop_i && (empty_i >= BPC_E);
    nvld      = BPC_E;
    if (eop_i) nvld = empty_bad ? '0 : (BPC_E - empty_i);
  end

  always_comb begin
    crc_nxt = crc_p0;
    for (int i = 0; i < N_HASH; i++) begin
      crc_nxt[i] = crc_beat(crc_p0[i], data_i, nvld);
    end
  end

  assign len_sum = sat_add(len_p0, nvld);

  // ---- stage p0: per-string accumulators; result register on eop ----
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      crc_p0      <= INIT_VEC;
      len_p0      <= '0;
      res_o       <= '0;
      len_o       <= '0;
      res_valid_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      if (res_valid_o && res_ready_i) res_valid_o <= 1'b0;
      if (accept) begin
        if (eop_i) begin
          // Emit this string and restart the accumulators with no bubble.
          res_o       <= crc_nxt;
          len_o       <= len_sum[LEN_W-1:0];
          res_valid_o <= 1'b1;
          crc_p0      <= INIT_VEC;
          len_p0      <= '0;
        end else begin
          crc_p0 <= crc_nxt;
          len_p0 <= len_sum[LEN_W-1:0];
        end
        if (empty_bad || len_sum[LEN_W]) err_o <= 1'b1;
      end
    end
  end

endmodule
